// File: rtl/pending_req_pkg.sv
// pending_req_pkg: shared constants and helpers for pending_req_tracker.
//   ERR_W / ERR_*   : width of the sticky error vector and the meaning of each bit.
//   MAX_N           : widest grant vector onehot_to_idx can decode.
//   onehot_to_idx() : returns 1 when exactly one bit is set; the index of the highest set
//                     bit is returned through the output argument.
package pending_req_pkg;

   localparam int unsigned ERR_W         = 3;
   localparam int unsigned ERR_OVF       = 0;
   localparam int unsigned ERR_EMPTY_GNT = 1;
   localparam int unsigned ERR_MULTI_GNT = 2;

   localparam int unsigned MAX_N = 256;

   function automatic logic onehot_to_idx(input logic [MAX_N-1:0] vec,
                                          output int unsigned idx);
      int unsigned ones;
      ones = 0;
      idx  = 0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         if (vec[i]) begin
            ones++;
            idx = i;
         end
      end
      return (ones == 1);
   endfunction

endpackage

// File: rtl/pending_req_cnt.sv
// pending_req_cnt: outstanding-request counter for a single requester.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   push       : new request pulse (accepted only while push_rdy is high)
//   gnt        : validated grant for this requester (already gated by the one-hot check)
//   push_rdy   : count < DEPTH
//   req        : count != 0
//   ovf        : push arrived while full (request dropped)
//   empty_gnt  : grant arrived while count is 0
module pending_req_cnt #(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic gnt,
   output logic push_rdy,
   output logic req,
   output logic ovf,
   output logic empty_gnt
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             inc, dec;

   // Ready and request come straight from the register: no path from push/gnt.
   assign push_rdy  = (cnt_q != FULL);
   assign req       = (cnt_q != '0);

   assign inc       = push & push_rdy;
   assign dec       = gnt & req;
   assign ovf       = push & ~push_rdy;
   assign empty_gnt = gnt & ~req;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({inc, dec})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pending_req_tracker.sv
// pending_req_tracker: per-requester pending-request counters feeding a fixed-priority
// arbiter, with a registered encoded grant and sticky protocol-error flags.
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   push_i      : per-requester request pulses
//   push_rdy_o  : per-requester "not full"
//   req_o       : per-requester "something pending" (to arbiter)
//   gnt_i       : arbiter grant (one-hot or zero expected)
//   gnt_vld_o   : a one-hot grant was sampled at the last edge
//   gnt_idx_o   : binary index of the last one-hot grant (holds otherwise)
//   err_o       : sticky [0] overflow, [1] grant to empty, [2] multi-hot grant
//   err_clr_i   : synchronous clear of err_o (a same-cycle new error still sets)
//   starve_o    : (PENDING_STARVE_MON_EN only) requester waited >= STARVE_LIMIT cycles
// Optional feature macro: PENDING_STARVE_MON_EN adds the starvation monitor and starve_o.
module pending_req_tracker
   import pending_req_pkg::*;
#(
   parameter int unsigned N            = 32,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [N-1:0]                        push_i,
   output logic [N-1:0]                        push_rdy_o,
   output logic [N-1:0]                        req_o,
   input  logic [N-1:0]                        gnt_i,
   output logic                                gnt_vld_o,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx_o,
   output logic [ERR_W-1:0]                    err_o,
   input  logic                                err_clr_i
`ifdef PENDING_STARVE_MON_EN
   ,
   output logic [N-1:0]                        starve_o
`endif
);

   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   if (N < 1 || N > MAX_N || DEPTH < 1 || STARVE_LIMIT < 1) begin : g_param_chk
      $error("pending_req_tracker: parameter out of range");
   end

   logic [MAX_N-1:0] gnt_ext;
   int unsigned      gnt_pos;
   logic             gnt_onehot;
   logic             gnt_multi;
   logic [N-1:0]     gnt_eff;
   logic [N-1:0]     ovf;
   logic [N-1:0]     empty_gnt;

   logic             gnt_vld_q;
   logic [IDX_W-1:0] gnt_idx_q;
   logic [ERR_W-1:0] err_q, err_d;

   // For N==1 the only one-hot pattern is 1, so the decoded index is 0 by construction.
   always_comb begin
      gnt_ext          = '0;
      gnt_ext[N-1:0]   = gnt_i;
      gnt_onehot       = onehot_to_idx(gnt_ext, gnt_pos);
   end

   assign gnt_multi = (|gnt_i) & ~gnt_onehot;
   // A multi-hot grant retires nothing and is not treated as a grant to any requester,
   // so it can only raise the multi-hot error, never the empty-grant error.
   assign gnt_eff   = gnt_i & {N{gnt_onehot}};

   for (genvar i = 0; i < N; i++) begin : g_cnt
      pending_req_cnt #(
         .DEPTH (DEPTH)
      ) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .push      (push_i[i]),
         .gnt       (gnt_eff[i]),
         .push_rdy  (push_rdy_o[i]),
         .req       (req_o[i]),
         .ovf       (ovf[i]),
         .empty_gnt (empty_gnt[i])
      );
   end

   // Clear first, then OR in this cycle's events so a coincident error survives the clear.
   always_comb begin
      err_d = err_clr_i ? '0 : err_q;
      if (|ovf)       err_d[ERR_OVF]       = 1'b1;
      if (|empty_gnt) err_d[ERR_EMPTY_GNT] = 1'b1;
      if (gnt_multi)  err_d[ERR_MULTI_GNT] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_vld_q <= 1'b0;
         gnt_idx_q <= '0;
         err_q     <= '0;
      end else begin
         gnt_vld_q <= gnt_onehot;
         if (gnt_onehot) begin
            gnt_idx_q <= IDX_W'(gnt_pos);
         end
         err_q     <= err_d;
      end
   end

   assign gnt_vld_o = gnt_vld_q;
   assign gnt_idx_o = gnt_idx_q;
   assign err_o     = err_q;

`ifdef PENDING_STARVE_MON_EN
   localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

   for (genvar i = 0; i < N; i++) begin : g_starve
      logic [WAIT_W-1:0] wait_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            wait_q <= '0;
         end else if (gnt_i[i] || !req_o[i]) begin
            wait_q <= '0;
         end else if (wait_q != WAIT_MAX) begin
            wait_q <= wait_q + WAIT_W'(1);
         end
      end

      assign starve_o[i] = (wait_q >= WAIT_MAX);
   end
`endif

endmodule

// File: doc/pending_req_tracker.md
Name: pending_req_tracker

Overview:
- Upstream feeder for the single-cycle fixed-priority arbiter.
- Per-requester counter of outstanding request pulses. Drives a level request vector into the arbiter; each grant retires one pending request.
- Registers the one-hot grant into an encoded index plus a valid strobe for the downstream datapath mux.
- Flags protocol errors: overflow, grant with nothing pending, non-one-hot grant.

Parameters:
- N, 32, number of requesters (≥1).
- DEPTH, 4, max outstanding requests per requester (≥1).
- CNT_W, $clog2(DEPTH+1), counter width (derived localparam, not overridable).
- IDX_W, (N>1)?$clog2(N):1, grant index width (derived localparam).
- STARVE_LIMIT, 16, wait-cycle threshold for the optional starvation monitor.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- push_i  input  N  per-requester request pulse; one new request per set bit per cycle.
- push_rdy_o  output  N  bit i = counter i < DEPTH; push accepted only when high.
- req_o  output  N  bit i = counter i != 0; connects to arbiter req_i.
- gnt_i  input  N  arbiter grant, expected one-hot or zero; sampled at rising clk.
- gnt_vld_o  output  1  registered: a valid grant was sampled last edge.
- gnt_idx_o  output  IDX_W  registered binary index of that grant.
- err_o  output  3  sticky: [0] push while not ready, [1] grant to empty counter, [2] gnt_i not one-hot.
- err_clr_i  input  1  synchronous clear of err_o.

Behaviour:
- Reset (async assert, sync-safe deassert assumed upstream) clears:
  - all counters to 0, so req_o=0 and push_rdy_o=all 1s;
  - gnt_vld_o=0, gnt_idx_o=0, err_o=0.
- Counter i update per edge: +1 if push_i[i]&push_rdy_o[i]; −1 if gnt_i[i] and count≠0.
  - Push and grant together on same i: count unchanged.
- Latency:
  - push at edge t → req_o[i] high after edge t (1 cycle).
  - Last grant at edge t → req_o[i] low after edge t.
- req_o, push_rdy_o: purely decoded from counter registers; no combinational path from push_i or gnt_i.
- Full (count==DEPTH):
  - push_rdy_o[i]=0; a push is dropped and sets err_o[0].
  - A simultaneous grant decrements the counter; the push is still dropped (ready was low).
- Empty grant: gnt_i[i] with count 0 → counter stays 0, err_o[1] set, gnt_vld_o still follows [2] rules.
- Grant register:
  - gnt_i one-hot → gnt_vld_o=1, gnt_idx_o=index.
  - gnt_i zero → gnt_vld_o=0, gnt_idx_o holds its previous value.
  - gnt_i multi-hot → err_o[2] set, gnt_vld_o=0, no counters decremented.
- Errors are sticky until err_clr_i or reset. If err_clr_i coincides with a new error event, the new error wins (bit set).
- N==1: gnt_idx_o tied 0; one-hot check reduces to gnt_i==1.
- Reset mid-operation discards all pending counts; no replay.

Optional Feature:
- Macro PENDING_STARVE_MON_EN.
- Defined:
  - Adds per-requester saturating wait counters (width $clog2(STARVE_LIMIT+1)).
  - Counter i increments each cycle req_o[i]=1 and gnt_i[i]=0; clears on grant or when count reaches 0.
  - Adds output port starve_o [N]; bit i high while wait counter i ≥ STARVE_LIMIT.
- Undefined: no wait counters, no starve_o port; behaviour otherwise identical.

Decomposition:
- Package pending_req_pkg holds:
  - error-bit position constants ERR_OVF=0, ERR_EMPTY_GNT=1, ERR_MULTI_GNT=2;
  - the err vector width localparam;
  - a function onehot_to_idx returning the index plus an is-one-hot flag.
- One natural sub-module: pending_req_cnt, a single requester's up/down saturating counter with ready/req decode, instantiated N times via generate.

Test Plan:
- Reset then idle: req_o=0, push_rdy_o=all 1s, gnt_vld_o=0, err_o=0.
- N=4, DEPTH=2. Push bit1 three consecutive cycles, no grants → count1=2, push_rdy_o[1]=0 after 2nd push, err_o[0]=1 after 3rd.
- Push bit2 once, gnt_i=4'b0100 next cycle → req_o[2] high one cycle then low; gnt_vld_o=1, gnt_idx_o=2 the cycle after the grant.
- Count0=1, apply push_i[0] and gnt_i=4'b0001 together → count0 stays 1, req_o[0] remains high.
- gnt_i=4'b0110 → err_o[2]=1, gnt_vld_o=0, counts unchanged. gnt_i=4'b1000 with count3=0 → err_o[1]=1.
- With PENDING_STARVE_MON_EN and STARVE_LIMIT=3, hold req_o[0] ungranted 3 cycles → starve_o[0]=1; grant → starve_o[0]=0 next cycle.
